// File: rtl/label_resolver.sv
// label_resolver: single post-frame pass that points every merge-table entry at its root
// and counts the root labels.
module label_resolver #(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] num_labels,
  output logic [WORD_SIZE-1:0] rd_addr,
  input  logic [WORD_SIZE-1:0] rd_data,
  output logic                 wr_en,
  output logic [WORD_SIZE-1:0] wr_addr,
  output logic [WORD_SIZE-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] label_count,
  output logic                 error
);
  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] READ_SELF    = 3'd1;
  localparam logic [2:0] CHECK_SELF   = 3'd2;
  localparam logic [2:0] READ_PARENT  = 3'd3;
  localparam logic [2:0] CHECK_PARENT = 3'd4;
  localparam logic [2:0] WRITE        = 3'd5;
  localparam logic [2:0] DONE         = 3'd6;
  logic [2:0] state;
  logic [WORD_SIZE-1:0] i, p, r, nl;
  logic last;
  assign last = i == nl - WORD_SIZE'(1);
  // ascending order guarantees T[p] is already a root, so one parent read suffices
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      i           <= '0;
      p           <= '0;
      r           <= '0;
      nl          <= '0;
      label_count <= '0;
      error       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          nl          <= num_labels;
          i           <= WORD_SIZE'(1);
          label_count <= '0;
          error       <= 1'b0;
          state       <= num_labels <= WORD_SIZE'(1) ? DONE : READ_SELF;
        end
        READ_SELF: state <= CHECK_SELF;
        CHECK_SELF: begin
          p <= rd_data;
          if (rd_data == i) begin
            label_count <= label_count + WORD_SIZE'(1);
            state       <= last ? DONE : READ_SELF;
            i           <= last ? i : i + WORD_SIZE'(1);
          end else if (rd_data == '0 || rd_data > i) begin
            error <= 1'b1;
            state <= last ? DONE : READ_SELF;
            i     <= last ? i : i + WORD_SIZE'(1);
          end else begin
            state <= READ_PARENT;
          end
        end
        READ_PARENT: state <= CHECK_PARENT;
        CHECK_PARENT: begin
          r     <= rd_data;
          state <= WRITE;
        end
        WRITE: begin
          state <= last ? DONE : READ_SELF;
          i     <= last ? i : i + WORD_SIZE'(1);
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    busy    = state != IDLE;
    done    = state == DONE;
    wr_en   = state == WRITE;
    wr_addr = wr_en ? i : '0;
    wr_data = wr_en ? r : '0;
    rd_addr = state == READ_SELF ? i : state == READ_PARENT ? p : '0;
  end
endmodule

// File: tb/tb_label_resolver.sv
// tb_label_resolver: directed runs against a bench-side merge-table RAM, checked by
// a flattening model of the table plus literal expectations.
module tb_label_resolver;
  typedef logic [7:0] tab_t [8];
  logic clk = 0, reset_n = 0, start = 0;
  logic [7:0] num_labels = 0, rd_addr, rd_data, wr_addr, wr_data, label_count;
  logic wr_en, busy, done, error;
  logic [7:0] mem [0:255];
  int checks = 0, errors = 0;
  bit mon = 0;
  int busy_n, done_n, first_done, wq, reads;
  logic [7:0] m_tab [0:255];
  logic [7:0] exp_wa [$], exp_wd [$];
  int m_cnt, m_busy, m_reads;
  bit m_err;

  always #5 clk = ~clk;

  label_resolver #(.WORD_SIZE(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_labels(num_labels),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .label_count(label_count), .error(error)
  );

  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) if (mon) begin
    if (busy) busy_n++;
    if (busy && rd_addr != 0) reads++;
    if (done) begin
      done_n++;
      if (first_done < 0) first_done = busy_n;
      chk("done_label_count", label_count, m_cnt);
      chk("done_error", error, m_err);
    end
    if (wr_en) begin
      if (wq < exp_wa.size()) begin
        chk("wr_addr", wr_addr, exp_wa[wq]);
        chk("wr_data", wr_data, exp_wd[wq]);
      end else chk("extra_write", wq, exp_wa.size());
      wq++;
    end else chk("idle_wr_bus", {wr_addr, wr_data}, 0);
    if (!busy) chk("idle_rd_addr", rd_addr, 0);
  end

  task automatic model(input int nl);
    int p;
    for (int k = 0; k < 256; k++) m_tab[k] = mem[k];
    exp_wa.delete(); exp_wd.delete();
    m_cnt = 0; m_err = 0; m_busy = 1; m_reads = 0;
    for (int k = 1; k < nl; k++) begin
      p = m_tab[k];
      if (p == k) begin m_cnt++; m_busy += 2; m_reads++; end
      else if (p == 0 || p > k) begin m_err = 1; m_busy += 2; m_reads++; end
      else begin
        m_tab[k] = m_tab[p];
        exp_wa.push_back(8'(k)); exp_wd.push_back(m_tab[p]);
        m_busy += 5; m_reads += 2;
      end
    end
  endtask

  task automatic load(input tab_t t);
    for (int k = 0; k < 256; k++) mem[k] = k < 8 ? t[k] : 8'h0;
  endtask

  task automatic run(input int nl, input tab_t t, input int restart_at);
    bit got = 0;
    load(t);
    model(nl);
    busy_n = 0; done_n = 0; first_done = -1; wq = 0; reads = 0;
    @(negedge clk);
    mon = 1; start = 1; num_labels = 8'(nl);
    @(posedge clk);
    #1 start = 0; num_labels = 8'hff;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = (k == restart_at);
      if (done) begin got = 1; break; end
    end
    @(posedge clk);
    #1 start = 0;
    chk("done_seen", got, 1);
    repeat (2) @(negedge clk);
    mon = 0;
    chk("busy_cycles", busy_n, m_busy);
    chk("done_pulses", done_n, 1);
    chk("done_in_last_busy_cycle", first_done, m_busy);
    chk("write_count", wq, exp_wa.size());
    chk("read_count", reads, m_reads);
    chk("label_count", label_count, m_cnt);
    chk("error", error, m_err);
    for (int k = 1; k < nl; k++) chk($sformatf("table[%0d]", k), mem[k], m_tab[k]);
  endtask

  initial begin
    tab_t t1, roots, bad;
    bit got;
    t1    = '{8'd0, 8'd1, 8'd1, 8'd3, 8'd2, 8'd3, 8'd0, 8'd0};
    roots = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0};
    bad   = '{8'd0, 8'd1, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int k = 0; k < 256; k++) mem[k] = 8'h0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_wr", {wr_en, wr_addr, wr_data}, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_count_err", {label_count, error}, 0);
    reset_n = 1;
    run(6, t1, 0);
    chk("t1_busy_lit", busy_n, 20);
    chk("t1_count_lit", label_count, 2);
    chk("t1_entry4_lit", mem[4], 1);
    chk("t1_entry5_lit", mem[5], 3);
    chk("t1_entry2_lit", mem[2], 1);
    run(1, t1, 0);
    chk("nl1_done_cycle_lit", first_done, 1);
    chk("nl1_reads_lit", reads, 0);
    chk("nl1_count_lit", label_count, 0);
    run(4, roots, 7);
    chk("roots_busy_lit", busy_n, 7);
    chk("roots_count_lit", label_count, 3);
    chk("roots_writes_lit", wq, 0);
    run(4, bad, 0);
    chk("bad_error_lit", error, 1);
    chk("bad_count_lit", label_count, 1);
    run(4, roots, 0);
    chk("clean_error_lit", error, 0);
    run(6, t1, 3);
    chk("restart_busy_lit", busy_n, 20);
    load(t1);
    @(negedge clk);
    start = 1; num_labels = 8'd6;
    @(posedge clk);
    #1 start = 0;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wr_en) begin got = 1; break; end
    end
    chk("reach_write", got, 1);
    #2 reset_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_wr", {wr_en, wr_addr, wr_data}, 0);
    chk("arst_rd_done", {rd_addr, done}, 0);
    chk("arst_count_err", {label_count, error}, 0);
    @(negedge clk);
    reset_n = 1;
    run(6, t1, 0);
    chk("post_reset_count_lit", label_count, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/label_resolver.md
# label_resolver

Post-frame controller for the connected-components merge table. After the labeler finishes a frame, it walks labels 1..num_labels-1 in ascending order and rewrites every merge-table entry to point directly at its root label. It also counts the distinct root labels. It owns the merge-table RAM port only while busy; the labeler holds it otherwise, with muxing done outside this block.

## Interface
- WORD_SIZE, 8: label width; merge-table address and data width.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to resolve the table; sampled only in IDLE.
- num_labels  in  WORD_SIZE  next free label from the labeler (labels 1..num_labels-1 are allocated; label 0 is reserved); sampled with start.
- rd_addr  out  WORD_SIZE  merge-table read address.
- rd_data  in  WORD_SIZE  merge-table read data, valid one cycle after rd_addr (registered RAM read).
- wr_en  out  1  merge-table write enable.
- wr_addr  out  WORD_SIZE  merge-table write address.
- wr_data  out  WORD_SIZE  merge-table write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the pass completes.
- label_count  out  WORD_SIZE  number of root labels found; valid from done until the next accepted start.
- error  out  1  sticky flag for a malformed entry; cleared on an accepted start.

## Operation
- Table invariant: every merge writes T[max]=min, so a non-root entry satisfies 0 < T[i] < i. Because labels are processed in ascending order, T[T[i]] is already a root when label i is reached, so a single pass fully flattens the table.
- Registers: index i, parent p, root r, label_count, error, and the latched num_labels (nl).
- IDLE: all outputs are 0 except label_count and error, which hold. On start: latch nl, set i=1, clear label_count and error. If nl<=1, go to DONE; otherwise go to READ_SELF.
- READ_SELF: drive rd_addr=i, then go to CHECK_SELF.
- CHECK_SELF: p=rd_data.
  - If p==i: the label is a root. Increment label_count and advance.
  - If p==0 or p>i: set error, skip the entry (no write, not counted) and advance.
  - Otherwise go to READ_PARENT.
- READ_PARENT: drive rd_addr=p, then go to CHECK_PARENT.
- CHECK_PARENT: r=rd_data, then go to WRITE.
- WRITE: wr_en=1, wr_addr=i, wr_data=r for exactly one cycle, then advance.
- Advance: if i==nl-1, go to DONE; otherwise i=i+1 and go to READ_SELF.
- DONE: done=1 for one cycle, then go to IDLE.
- Every path writes at most one entry per label, and never writes a root entry.
- Arithmetic: i, p and nl are WORD_SIZE unsigned. The comparison i==nl-1 guarantees i never wraps. label_count never exceeds nl-1, so it cannot overflow.
- rd_addr is 0 in every state except READ_SELF and READ_PARENT. wr_addr and wr_data are 0 whenever wr_en=0.

## Timing
- Reset (asynchronous, any state): state=IDLE; busy, done, wr_en, error, rd_addr, wr_addr, wr_data and label_count all 0.
- Start is accepted at edge E0; busy rises in the cycle after E0.
- Cost per label: a root or error entry takes 2 cycles; a non-root entry takes 5 cycles.
- The DONE cycle adds 1. Total busy cycles = sum of per-label costs + 1. With nl<=1, busy lasts exactly 1 cycle, which is the DONE cycle.
- Read hazard: T[i] is written at the WRITE edge. Any later read of address i occurs at least one cycle after that edge, so it sees the new value and no bypass is needed.
- start while busy is ignored: no restart and no state change.
- start in the same cycle as the done pulse is ignored, because that cycle is the DONE state, not IDLE.
- num_labels changes while busy have no effect, because nl is latched.

## Test plan
- nl=6, T=[-,1,1,3,2,3]:
  - Result T=[-,1,1,3,1,3]; writes only to addresses 2, 4 and 5, with data 1, 1, 3.
  - label_count=2, error=0, busy for 20 cycles, done pulses once.
- nl=1, start: no reads and no writes; done is asserted in the 1st cycle after E0; label_count=0.
- nl=4, T=[-,1,2,3] (all roots): wr_en never asserts; label_count=3; busy for 7 cycles.
- nl=4, T=[-,1,3,0]:
  - error=1, label_count=1, no writes.
  - A subsequent start with a clean table clears error.
- Pulse start again 3 cycles into a pass: no effect; the cycle count is identical to an undisturbed run.
- Assert reset_n=0 mid-pass, during WRITE, asynchronously between edges:
  - busy, wr_en and all other outputs go to 0 at once.
  - After release, a new start completes correctly.
